// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit: FSM states, funct3 codes,
// access size and byte-enable generation.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication and byte enables from the core
// request, load lane extraction and sign/zero extension from the raw bus word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [2:0]  i_st_funct,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_funct,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be = be_gen(f3_size(i_st_funct), i_st_off);
    case (f3_size(i_st_funct))
      SZ_B:    o_wdata = {4{i_st_wdata[7:0]}};
      SZ_H:    o_wdata = {2{i_st_wdata[15:0]}};
      default: o_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one bus transaction per request, min 3 cycles to DONE, stalls core while REQ/WAIT.
// Optional bus watchdog under DMEM_TIMEOUT_EN; otherwise waits on the bus indefinitely.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [2:0]      mem_funct,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_stall,
  output logic            mem_misalign,
  output logic            mem_fault,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  lsu_state_t  r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_funct;

  logic        w_req, w_legal_f3, w_misal, w_accept, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_data, w_cap_data;

  assign w_req = mem_rd | mem_wr;

  always_comb begin
    w_legal_f3 = 1'b0;
    case (mem_funct)
      F3_B, F3_H, F3_W: w_legal_f3 = 1'b1;
      F3_BU, F3_HU:     w_legal_f3 = ~mem_wr;
      default:          w_legal_f3 = 1'b0;
    endcase
  end

  assign w_misal  = ((f3_size(mem_funct) == SZ_H) & mem_addr[0]) |
                    ((f3_size(mem_funct) == SZ_W) & (mem_addr[1:0] != 2'b00));
  assign w_accept = (r_state == IDLE) & w_req & ~(mem_rd & mem_wr) & w_legal_f3 & ~w_misal;

  assign mem_stall = w_accept | (r_state == REQ) | (r_state == WAIT);

  dmem_lane_align u_align (
    .i_st_off   (mem_addr[1:0]),
    .i_st_funct (mem_funct),
    .i_st_wdata (mem_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_off   (r_off),
    .i_ld_funct (r_funct),
    .i_rdata    (bus_rdata),
    .o_ld_data  (w_ld_data)
  );

  // Stores and errored responses both hand back zero.
  assign w_cap_data = (bus_err | bus_we) ? 32'h0 : w_ld_data;

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  assign w_tmo = (r_tmo == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset || !((r_state == REQ) || (r_state == WAIT))) r_tmo <= '0;
    else                                                    r_tmo <= r_tmo + 1'b1;
  end
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_off         <= 2'b00;
      r_funct       <= 3'b000;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= 4'b0000;
      bus_wdata     <= '0;
      mem_rdata     <= '0;
      mem_misalign  <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      mem_misalign <= 1'b0;
      mem_fault    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if ((mem_rd & mem_wr) | ~w_legal_f3) begin
              mem_fault <= 1'b1;
            end else if (w_misal) begin
              mem_misalign <= 1'b1;
            end else begin
              r_off         <= mem_addr[1:0];
              r_funct       <= mem_funct;
              bus_we        <= mem_wr;
              bus_addr      <= {mem_addr[XLEN-1:2], 2'b00};
              bus_be        <= w_be;
              bus_wdata     <= w_wdata;
              bus_req_valid <= 1'b1;
              r_state       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            if (bus_rsp_valid) begin
              mem_rdata <= w_cap_data;
              mem_fault <= bus_err;
              r_state   <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end else if (w_tmo) begin
            bus_req_valid <= 1'b0;
            mem_rdata     <= '0;
            mem_fault     <= 1'b1;
            r_state       <= DONE;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            mem_rdata <= w_cap_data;
            mem_fault <= bus_err;
            r_state   <= DONE;
          end else if (w_tmo) begin
            mem_rdata <= '0;
            mem_fault <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
